// File: rtl/imm_ext_pkg.sv
// rtl/imm_ext_pkg.sv - shared types and constants for the immediate-extension pipe
package imm_ext_pkg;

   // Operand format selected by in_mode; every encoding is defined
   typedef enum logic [1:0] {
      SEXT     = 2'd0,
      ZEXT     = 2'd1,
      SEXT_SHL = 2'd2,
      UPPER    = 2'd3
   } imm_mode_e;

   // Occupancy of the two-entry output buffer
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } buf_state_e;

   // Width of each per-mode accept counter
   localparam int STAT_W = 16;

endpackage

// File: rtl/imm_ext_skid.sv
// rtl/imm_ext_skid.sv - generic two-entry skid buffer with registered in_ready
module imm_ext_skid
   import imm_ext_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   buf_state_e   state;
   buf_state_e   state_nxt;
   logic [W-1:0] main_q;
   logic [W-1:0] skid_q;
   logic         accept;
   logic         drain;
   logic         load_main;
   logic         load_skid;
   logic         main_from_skid;

   assign accept    = in_valid & in_ready;
   assign drain     = out_valid & out_ready;
   assign out_valid = (state != EMPTY);
   assign out_data  = main_q;

   // State register; in_ready is precomputed so it never sees out_ready combinationally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= EMPTY;
         in_ready <= 1'b1;
      end else begin
         state    <= state_nxt;
         in_ready <= (state_nxt != FULL);
      end
   end

   // Next-state and register-load decode
   always_comb begin
      state_nxt      = state;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
      case (state)
         EMPTY: begin
            if (accept) begin
               state_nxt = BUSY;
               load_main = 1'b1;
            end
         end
         BUSY: begin
            if (accept && drain) begin
               load_main = 1'b1;
            end else if (accept) begin
               state_nxt = FULL;
               load_skid = 1'b1;
            end else if (drain) begin
               state_nxt = EMPTY;
            end
         end
         FULL: begin
            if (drain) begin
               state_nxt      = BUSY;
               main_from_skid = 1'b1;
            end
         end
         default: state_nxt = EMPTY;
      endcase
   end

   // Data registers: main feeds the output, skid catches the entry that arrived under stall
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (load_main) begin
            main_q <= in_data;
         end else if (main_from_skid) begin
            main_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= in_data;
         end
      end
   end

endmodule

// File: rtl/imm_ext_pipe.sv
// rtl/imm_ext_pipe.sv - pipelined immediate extension with skid-buffered output (option: IMM_EXT_STATS_EN)
module imm_ext_pipe
   import imm_ext_pkg::*;
#(
   parameter int IN_W  = 18,
   parameter int OUT_W = 32,
   parameter int SHIFT = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [IN_W-1:0]        in_imm,
   input  logic [1:0]             in_mode,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [OUT_W-1:0]       out_imm,
`ifdef IMM_EXT_STATS_EN
   output logic [3:0][STAT_W-1:0] stat_cnt,
`endif
   output logic [1:0]             out_mode
);

   // The shifted sign-extended form must fit without losing its top bits
   if (OUT_W <= IN_W + SHIFT) begin : g_bad_params
      $error("imm_ext_pipe: OUT_W must exceed IN_W + SHIFT");
   end

   logic [OUT_W-1:0]   sext;
   logic [OUT_W-1:0]   zext;
   logic [OUT_W-1:0]   upper;
   logic [OUT_W-1:0]   ext;
   logic [OUT_W+1:0]   buf_out;

   assign sext  = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};
   assign zext  = {{(OUT_W-IN_W){1'b0}}, in_imm};
   assign upper = {in_imm, {(OUT_W-IN_W){1'b0}}};

   // Format mux on the input side so the buffer only stores finished operands
   always_comb begin
      ext = sext;
      case (imm_mode_e'(in_mode))
         SEXT:     ext = sext;
         ZEXT:     ext = zext;
         SEXT_SHL: ext = sext << SHIFT;
         UPPER:    ext = upper;
         default:  ext = sext;
      endcase
   end

   imm_ext_skid #(
      .W (OUT_W + 2)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   ({in_mode, ext}),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (buf_out)
   );

   assign out_imm  = buf_out[OUT_W-1:0];
   assign out_mode = buf_out[OUT_W+1:OUT_W];

`ifdef IMM_EXT_STATS_EN
   // Per-mode accept counters, saturating at all-ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_cnt <= '0;
      end else if (in_valid && in_ready) begin
         for (int i = 0; i < 4; i++) begin
            if (in_mode == 2'(i) && stat_cnt[i] != {STAT_W{1'b1}}) begin
               stat_cnt[i] <= stat_cnt[i] + STAT_W'(1);
            end
         end
      end
   end
`endif

endmodule
